// File: rtl/game_phase_ctrl.sv
// -----------------------------------------------------------------------------
// game_phase_ctrl
// Sequences one game round through IDLE -> READY -> PLAY <-> PAUSE -> OVER ->
// IDLE and owns the game-seconds prescaler. The prescaler only advances in
// the timed phases, holds across a PAUSE, and restarts at every phase entry
// except the PLAY/PAUSE toggles, so a pause never gains or loses counts.
//
// Ports:
//   clk25       in   1  system clock, rising edge
//   reset_n     in   1  synchronous active-low reset
//   start       in   1  pulse: begin a game (IDLE only)
//   pause       in   1  pulse: toggle PLAY / PAUSE
//   player_dead in   1  pulse: end PLAY early
//   phase       out  3  0 IDLE, 1 READY, 2 PLAY, 3 PAUSE, 4 OVER
//   time_left   out  8  seconds remaining in the current timed phase
//   play_secs   out  8  elapsed PLAY seconds, saturating at 255
//   sec_tick    out  1  one-cycle pulse per elapsed game second
//   survived    out  1  PLAY ended by timeout
// -----------------------------------------------------------------------------
module game_phase_ctrl #(
  parameter int unsigned TICKS_PER_SEC = 25_000_000,
  parameter int unsigned READY_SECS    = 3,
  parameter int unsigned ROUND_SECS    = 60,
  parameter int unsigned OVER_SECS     = 5
) (
  input  logic       clk25,
  input  logic       reset_n,
  input  logic       start,
  input  logic       pause,
  input  logic       player_dead,
  output logic [2:0] phase,
  output logic [7:0] time_left,
  output logic [7:0] play_secs,
  output logic       sec_tick,
  output logic       survived
);

  localparam logic [2:0] PH_IDLE  = 3'd0;
  localparam logic [2:0] PH_READY = 3'd1;
  localparam logic [2:0] PH_PLAY  = 3'd2;
  localparam logic [2:0] PH_PAUSE = 3'd3;
  localparam logic [2:0] PH_OVER  = 3'd4;

  localparam logic [24:0] PRESC_MAX  = 25'(TICKS_PER_SEC - 1);
  localparam logic [7:0]  READY_LOAD = 8'(READY_SECS);
  localparam logic [7:0]  ROUND_LOAD = 8'(ROUND_SECS);
  localparam logic [7:0]  OVER_LOAD  = 8'(OVER_SECS);

  logic [2:0]  phase_q, phase_d;
  logic [24:0] presc_q, presc_d;
  logic [7:0]  time_left_q, time_left_d;
  logic [7:0]  play_secs_q, play_secs_d;
  logic        sec_tick_q, sec_tick_d;
  logic        survived_q, survived_d;
  // Set for the single cycle after a timeout entry into OVER, when time_left
  // still shows 0 and OVER_SECS must be loaded on the following edge.
  logic        over_load_q, over_load_d;

  logic        wrap_s;
  logic [24:0] presc_inc_s;
  logic [7:0]  tl_dec_s;
  logic [7:0]  play_inc_s;

  assign wrap_s      = (presc_q == PRESC_MAX);
  assign presc_inc_s = presc_q + 25'd1;
  assign tl_dec_s    = (time_left_q == 8'd0) ? 8'd0 : (time_left_q - 8'd1);
  assign play_inc_s  = (play_secs_q == 8'd255) ? 8'd255 : (play_secs_q + 8'd1);

  // Next-state logic for phase, prescaler and all output registers.
  always_comb begin
    phase_d     = phase_q;
    presc_d     = presc_q;
    time_left_d = time_left_q;
    play_secs_d = play_secs_q;
    sec_tick_d  = 1'b0;
    survived_d  = survived_q;
    over_load_d = 1'b0;

    case (phase_q)
      PH_IDLE: begin
        presc_d = 25'd0;
        if (start) begin
          phase_d     = PH_READY;
          time_left_d = READY_LOAD;
          play_secs_d = 8'd0;
          survived_d  = 1'b0;
        end else begin
          phase_d = PH_IDLE;
        end
      end

      PH_READY: begin
        if (wrap_s) begin
          presc_d    = 25'd0;
          sec_tick_d = 1'b1;
          if (time_left_q == 8'd1) begin
            phase_d     = PH_PLAY;
            time_left_d = ROUND_LOAD;
          end else begin
            time_left_d = tl_dec_s;
          end
        end else begin
          presc_d = presc_inc_s;
        end
      end

      PH_PLAY: begin
        if (player_dead) begin
          // Death beats a coincident final wrap, but that wrap still counts.
          phase_d     = PH_OVER;
          survived_d  = 1'b0;
          time_left_d = OVER_LOAD;
          presc_d     = 25'd0;
          if (wrap_s) begin
            play_secs_d = play_inc_s;
            sec_tick_d  = 1'b1;
          end else begin
            play_secs_d = play_secs_q;
          end
        end else if (wrap_s && (time_left_q == 8'd1)) begin
          phase_d     = PH_OVER;
          survived_d  = 1'b1;
          time_left_d = 8'd0;
          play_secs_d = play_inc_s;
          sec_tick_d  = 1'b1;
          presc_d     = 25'd0;
          over_load_d = 1'b1;
        end else if (pause) begin
          // The pausing edge does not count, so the held value resumes exactly.
          phase_d = PH_PAUSE;
          presc_d = presc_q;
        end else if (wrap_s) begin
          presc_d     = 25'd0;
          time_left_d = tl_dec_s;
          play_secs_d = play_inc_s;
          sec_tick_d  = 1'b1;
        end else begin
          presc_d = presc_inc_s;
        end
      end

      PH_PAUSE: begin
        if (pause) begin
          phase_d = PH_PLAY;
        end else begin
          phase_d = PH_PAUSE;
        end
      end

      PH_OVER: begin
        if (wrap_s) begin
          presc_d = 25'd0;
          if (time_left_q == 8'd1) begin
            // No tick here: it would land in IDLE.
            phase_d     = PH_IDLE;
            time_left_d = 8'd0;
          end else begin
            time_left_d = tl_dec_s;
            sec_tick_d  = 1'b1;
          end
        end else begin
          presc_d = presc_inc_s;
          if (over_load_q) begin
            time_left_d = OVER_LOAD;
          end else begin
            time_left_d = time_left_q;
          end
        end
      end

      default: begin
        phase_d     = PH_IDLE;
        presc_d     = 25'd0;
        time_left_d = 8'd0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk25) begin
    if (!reset_n) begin
      phase_q     <= PH_IDLE;
      presc_q     <= 25'd0;
      time_left_q <= 8'd0;
      play_secs_q <= 8'd0;
      sec_tick_q  <= 1'b0;
      survived_q  <= 1'b0;
      over_load_q <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      presc_q     <= presc_d;
      time_left_q <= time_left_d;
      play_secs_q <= play_secs_d;
      sec_tick_q  <= sec_tick_d;
      survived_q  <= survived_d;
      over_load_q <= over_load_d;
    end
  end

  assign phase     = phase_q;
  assign time_left = time_left_q;
  assign play_secs = play_secs_q;
  assign sec_tick  = sec_tick_q;
  assign survived  = survived_q;

endmodule

// File: tb/tb_game_phase_ctrl.sv
// -----------------------------------------------------------------------------
// tb_game_phase_ctrl
// Two instances: A (TICKS_PER_SEC=4, READY=3, ROUND=5, OVER=2) for the round,
// death, pause, priority, reset and random scenarios; B (TICKS_PER_SEC=2,
// ROUND=255) for play_secs saturation. The reference model tracks counted
// cycles per phase and derives time_left / play_secs arithmetically.
// -----------------------------------------------------------------------------
module tb_game_phase_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rstn, a_start, a_pause, a_dead;
  logic [2:0] a_phase;
  logic [7:0] a_tl, a_ps;
  logic       a_tick, a_surv;
  logic       b_rstn, b_start, b_pause, b_dead;
  logic [2:0] b_phase;
  logic [7:0] b_tl, b_ps;
  logic       b_tick, b_surv;
  logic [20:0] a_obs, b_obs;

  assign a_obs = {a_phase, a_tl, a_ps, a_tick, a_surv};
  assign b_obs = {b_phase, b_tl, b_ps, b_tick, b_surv};

  game_phase_ctrl #(.TICKS_PER_SEC(4), .READY_SECS(3), .ROUND_SECS(5), .OVER_SECS(2)) u_a (
    .clk25(clk), .reset_n(a_rstn), .start(a_start), .pause(a_pause), .player_dead(a_dead),
    .phase(a_phase), .time_left(a_tl), .play_secs(a_ps), .sec_tick(a_tick), .survived(a_surv));

  game_phase_ctrl #(.TICKS_PER_SEC(2), .READY_SECS(3), .ROUND_SECS(255), .OVER_SECS(2)) u_b (
    .clk25(clk), .reset_n(b_rstn), .start(b_start), .pause(b_pause), .player_dead(b_dead),
    .phase(b_phase), .time_left(b_tl), .play_secs(b_ps), .sec_tick(b_tick), .survived(b_surv));

  int chk  = 0;
  int pass = 0;

  // Reference model: phase, counted cycles in the current timed phase, counted
  // PLAY cycles overall, survived, tick, and the "show 0 after timeout" flag.
  typedef struct packed {
    int ph;
    int cnt;
    int play;
    int surv;
    int tick;
    int show0;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t mstep(mdl_t m, int T, int RS, int PS, int OS,
                                 logic rn, logic st, logic pa, logic dd);
    mdl_t n;
    n = m;
    n.tick  = 0;
    n.show0 = 0;
    if (!rn) begin
      n = '0;
    end else if (m.ph == 0) begin
      if (st) begin
        n.ph = 1; n.cnt = 0; n.play = 0; n.surv = 0;
      end
    end else if (m.ph == 1) begin
      n.cnt  = m.cnt + 1;
      n.tick = (n.cnt % T == 0) ? 1 : 0;
      if (n.cnt == RS * T) begin n.ph = 2; n.cnt = 0; end
    end else if (m.ph == 2) begin
      if (dd) begin
        n.play = m.play + 1;
        n.tick = ((m.cnt + 1) % T == 0) ? 1 : 0;
        n.ph = 4; n.surv = 0; n.cnt = 0;
      end else if (m.cnt + 1 == PS * T) begin
        n.play = m.play + 1; n.tick = 1;
        n.ph = 4; n.surv = 1; n.cnt = 0; n.show0 = 1;
      end else if (pa) begin
        n.ph = 3;
      end else begin
        n.cnt  = m.cnt + 1;
        n.play = m.play + 1;
        n.tick = (n.cnt % T == 0) ? 1 : 0;
      end
    end else if (m.ph == 3) begin
      if (pa) n.ph = 2;
    end else begin
      n.cnt  = m.cnt + 1;
      n.tick = (n.cnt % T == 0) ? 1 : 0;
      if (n.cnt == OS * T) begin n.ph = 0; n.cnt = 0; n.tick = 0; end
    end
    return n;
  endfunction

  function automatic logic [20:0] mexp(mdl_t m, int T, int RS, int PS, int OS);
    int tl, ps;
    if (m.ph == 0)      tl = 0;
    else if (m.ph == 1) tl = RS - m.cnt / T;
    else if (m.ph == 4) tl = (m.show0 != 0) ? 0 : OS - m.cnt / T;
    else                tl = PS - m.cnt / T;
    ps = (m.play / T > 255) ? 255 : m.play / T;
    return {m.ph[2:0], tl[7:0], ps[7:0], m.tick[0], m.surv[0]};
  endfunction

  function automatic logic [20:0] exp_a();
    return mexp(ma, 4, 3, 5, 2);
  endfunction

  function automatic logic [20:0] exp_b();
    return mexp(mb, 2, 3, 255, 2);
  endfunction

  task automatic step_a(input logic st, input logic pa, input logic dd, input logic rn);
    a_start = st; a_pause = pa; a_dead = dd; a_rstn = rn;
    @(posedge clk);
    ma = mstep(ma, 4, 3, 5, 2, rn, st, pa, dd);
    #1;
    a_start = 1'b0; a_pause = 1'b0; a_dead = 1'b0; a_rstn = 1'b1;
  endtask

  task automatic step_b(input logic st, input logic rn);
    b_start = st; b_pause = 1'b0; b_dead = 1'b0; b_rstn = rn;
    @(posedge clk);
    mb = mstep(mb, 2, 3, 255, 2, rn, st, 1'b0, 1'b0);
    #1;
    b_start = 1'b0; b_rstn = 1'b1;
  endtask

  // Advance A with idle inputs until the phase is reached or the bound expires.
  task automatic advance_a(input logic [2:0] ph, output int n);
    n = 0;
    while (a_phase !== ph && n < 2000) begin
      step_a(1'b0, 1'b0, 1'b0, 1'b1);
      n++;
    end
  endtask

  task automatic test_reset();
    step_a(1'b0, 1'b0, 1'b0, 1'b0);
    step_a(1'b0, 1'b0, 1'b0, 1'b0);
    chk++;
    if (a_obs !== 21'd0) $display("FAIL reset_state: got %h want %h", a_obs, 21'd0);
    else pass++;
  endtask

  task automatic test_full_round();
    int n;
    step_a(1'b1, 1'b0, 1'b0, 1'b1);
    chk++;
    if (a_phase !== 3'd1 || a_tl !== 8'd3)
      $display("FAIL full_ready_entry: phase=%0d tl=%0d want 1/3", a_phase, a_tl);
    else pass++;
    n = 0;
    while (a_phase !== 3'd2 && n < 100) begin
      step_a(1'b0, 1'b0, 1'b0, 1'b1); n++;
      chk++;
      if (a_obs !== exp_a()) $display("FAIL full_ready_model: got %h want %h", a_obs, exp_a());
      else pass++;
    end
    chk++;
    if (n !== 12 || a_tl !== 8'd5)
      $display("FAIL full_ready_len: cycles=%0d tl=%0d want 12/5", n, a_tl);
    else pass++;
    n = 0;
    while (a_phase !== 3'd4 && n < 100) begin
      step_a(1'b0, 1'b0, 1'b0, 1'b1); n++;
      chk++;
      if (a_obs !== exp_a()) $display("FAIL full_play_model: got %h want %h", a_obs, exp_a());
      else pass++;
    end
    chk++;
    if (n !== 20 || a_surv !== 1'b1 || a_ps !== 8'd5 || a_tl !== 8'd0)
      $display("FAIL full_timeout: cycles=%0d surv=%0d ps=%0d tl=%0d want 20/1/5/0", n, a_surv, a_ps, a_tl);
    else pass++;
    step_a(1'b0, 1'b0, 1'b0, 1'b1);
    n = 1;
    chk++;
    if (a_tl !== 8'd2) $display("FAIL full_over_load: tl=%0d want 2", a_tl);
    else pass++;
    while (a_phase !== 3'd0 && n < 100) begin
      step_a(1'b0, 1'b0, 1'b0, 1'b1); n++;
      chk++;
      if (a_obs !== exp_a()) $display("FAIL full_over_model: got %h want %h", a_obs, exp_a());
      else pass++;
    end
    chk++;
    if (n !== 8) $display("FAIL full_over_len: cycles=%0d want 8", n);
    else pass++;
  endtask

  task automatic test_death();
    int n;
    step_a(1'b1, 1'b0, 1'b0, 1'b1);
    advance_a(3'd2, n);
    repeat (5) step_a(1'b0, 1'b0, 1'b0, 1'b1);
    step_a(1'b0, 1'b0, 1'b1, 1'b1);
    chk++;
    if (a_phase !== 3'd4 || a_surv !== 1'b0 || a_ps !== 8'd1 || a_tl !== 8'd2)
      $display("FAIL death_over: phase=%0d surv=%0d ps=%0d tl=%0d want 4/0/1/2", a_phase, a_surv, a_ps, a_tl);
    else pass++;
    advance_a(3'd0, n);
    chk++;
    if (n !== 8) $display("FAIL death_over_len: cycles=%0d want 8", n);
    else pass++;
  endtask

  task automatic test_pause();
    int n, pre;
    step_a(1'b1, 1'b0, 1'b0, 1'b1);
    advance_a(3'd2, n);
    pre = 2 + 4 * int'($urandom_range(0, 3));
    repeat (pre) step_a(1'b0, 1'b0, 1'b0, 1'b1);
    step_a(1'b0, 1'b1, 1'b0, 1'b1);
    chk++;
    if (a_phase !== 3'd3) $display("FAIL pause_enter: phase=%0d want 3", a_phase);
    else pass++;
    for (int i = 0; i < 50; i++) begin
      step_a(1'b0, 1'b0, 1'b0, 1'b1);
      chk++;
      if (a_tick !== 1'b0 || a_obs !== exp_a())
        $display("FAIL pause_hold: got %h want %h", a_obs, exp_a());
      else pass++;
    end
    step_a(1'b0, 1'b1, 1'b0, 1'b1);
    chk++;
    if (a_phase !== 3'd2) $display("FAIL pause_resume: phase=%0d want 2", a_phase);
    else pass++;
    step_a(1'b0, 1'b0, 1'b0, 1'b1);
    step_a(1'b0, 1'b0, 1'b0, 1'b1);
    chk++;
    if (a_tick !== 1'b1) $display("FAIL pause_next_tick: tick=%0d want 1", a_tick);
    else pass++;
    advance_a(3'd4, n);
    chk++;
    if (pre + 1 + 50 + 1 + 2 + n !== 72 || a_surv !== 1'b1)
      $display("FAIL pause_play_len: cycles=%0d surv=%0d want 72/1", pre + 54 + n, a_surv);
    else pass++;
    advance_a(3'd0, n);
  endtask

  task automatic test_priority();
    int n;
    // Death and pause on the final wrap: death wins.
    step_a(1'b1, 1'b0, 1'b0, 1'b1);
    advance_a(3'd2, n);
    repeat (19) step_a(1'b0, 1'b0, 1'b0, 1'b1);
    step_a(1'b0, 1'b1, 1'b1, 1'b1);
    chk++;
    if (a_phase !== 3'd4 || a_surv !== 1'b0 || a_ps !== 8'd5 || a_tl !== 8'd2 || a_tick !== 1'b1)
      $display("FAIL prio_dead_wrap: got %h want phase4 surv0 ps5 tl2 tick1", a_obs);
    else pass++;
    step_a(1'b1, 1'b0, 1'b0, 1'b1);
    chk++;
    if (a_phase !== 3'd4 || a_obs !== exp_a()) $display("FAIL prio_start_over: got %h want %h", a_obs, exp_a());
    else pass++;
    advance_a(3'd0, n);
    // Pause on the final wrap: the timeout wins.
    step_a(1'b1, 1'b0, 1'b0, 1'b1);
    step_a(1'b1, 1'b0, 1'b0, 1'b1);
    chk++;
    if (a_phase !== 3'd1 || a_tl !== 8'd3) $display("FAIL prio_start_ready: phase=%0d tl=%0d want 1/3", a_phase, a_tl);
    else pass++;
    advance_a(3'd2, n);
    chk++;
    if (n !== 11) $display("FAIL prio_ready_len: cycles=%0d want 11", n);
    else pass++;
    repeat (19) step_a(1'b0, 1'b0, 1'b0, 1'b1);
    step_a(1'b0, 1'b1, 1'b0, 1'b1);
    chk++;
    if (a_phase !== 3'd4 || a_surv !== 1'b1 || a_tl !== 8'd0)
      $display("FAIL prio_pause_wrap: phase=%0d surv=%0d tl=%0d want 4/1/0", a_phase, a_surv, a_tl);
    else pass++;
    advance_a(3'd0, n);
    // Start and death in PAUSE are ignored.
    step_a(1'b1, 1'b0, 1'b0, 1'b1);
    advance_a(3'd2, n);
    step_a(1'b0, 1'b1, 1'b0, 1'b1);
    step_a(1'b1, 1'b0, 1'b1, 1'b1);
    chk++;
    if (a_phase !== 3'd3 || a_obs !== exp_a()) $display("FAIL prio_start_pause: got %h want %h", a_obs, exp_a());
    else pass++;
    step_a(1'b0, 1'b1, 1'b0, 1'b1);
    step_a(1'b0, 1'b0, 1'b1, 1'b1);
    advance_a(3'd0, n);
  endtask

  task automatic test_reset_mid();
    int n;
    step_a(1'b1, 1'b0, 1'b0, 1'b1);
    advance_a(3'd2, n);
    repeat (8) step_a(1'b0, 1'b0, 1'b0, 1'b1);
    chk++;
    if (a_tl !== 8'd3) $display("FAIL rst_mid_setup: tl=%0d want 3", a_tl);
    else pass++;
    step_a(1'b0, 1'b0, 1'b0, 1'b0);
    chk++;
    if (a_obs !== 21'd0) $display("FAIL rst_mid_zero: got %h want %h", a_obs, 21'd0);
    else pass++;
    repeat (3) step_a(1'b0, 1'b0, 1'b0, 1'b1);
    step_a(1'b1, 1'b0, 1'b0, 1'b1);
    advance_a(3'd2, n);
    chk++;
    if (n !== 12) $display("FAIL rst_mid_restart: ready cycles=%0d want 12", n);
    else pass++;
    step_a(1'b0, 1'b0, 1'b1, 1'b1);
    advance_a(3'd0, n);
  endtask

  task automatic test_random();
    logic st, pa, dd, rn;
    for (int i = 0; i < 1500; i++) begin
      st = ($urandom_range(0, 99) < 15);
      pa = ($urandom_range(0, 99) < 8);
      dd = ($urandom_range(0, 99) < 2);
      rn = ($urandom_range(0, 499) != 0);
      step_a(st, pa, dd, rn);
      chk++;
      if (a_obs !== exp_a()) $display("FAIL random_model: cycle %0d got %h want %h", i, a_obs, exp_a());
      else pass++;
    end
  endtask

  task automatic test_saturation();
    int n;
    logic [7:0] prev;
    step_b(1'b0, 1'b0);
    step_b(1'b1, 1'b1);
    n = 0;
    prev = 8'd0;
    while (b_phase !== 3'd4 && n < 1000) begin
      step_b(1'b0, 1'b1); n++;
      chk++;
      if (b_obs !== exp_b() || b_ps < prev) $display("FAIL sat_model: got %h want %h", b_obs, exp_b());
      else pass++;
      prev = b_ps;
    end
    chk++;
    if (b_phase !== 3'd4 || b_ps !== 8'd255 || b_surv !== 1'b1)
      $display("FAIL sat_timeout: phase=%0d ps=%0d surv=%0d want 4/255/1", b_phase, b_ps, b_surv);
    else pass++;
    repeat (6) step_b(1'b0, 1'b1);
    chk++;
    if (b_phase !== 3'd0 || b_ps !== 8'd255) $display("FAIL sat_hold: phase=%0d ps=%0d want 0/255", b_phase, b_ps);
    else pass++;
  endtask

  initial begin
    ma = '0; mb = '0;
    a_rstn = 1'b0; a_start = 1'b0; a_pause = 1'b0; a_dead = 1'b0;
    b_rstn = 1'b0; b_start = 1'b0; b_pause = 1'b0; b_dead = 1'b0;
    test_reset();
    test_full_round();
    test_death();
    test_pause();
    test_priority();
    test_reset_mid();
    test_random();
    test_saturation();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end

endmodule
